// File: rtl/mac_out_pack.sv
// mac_out_pack: output packer that sits after the MAC engine.
// Takes the signed 32-bit result stream d. Each result can be saturated to 16 or 8 bits.
// It packs 1, 2 or 4 results into one 32-bit word and marks the end of every reg_num-result
// frame with o_TLAST and o_TKEEP.
// Ports:
//   ap_clk, ap_rst          clock and synchronous active-high reset
//   d_TVALID/TREADY/TDATA   input result stream (signed 32-bit)
//   o_TVALID/TREADY/TDATA   packed output word stream, lane 0 in the LSBs
//   o_TKEEP, o_TLAST        byte-valid mask and end-of-frame flag of the output word
//   reg_mode                0: 32b, 1: 16b x2, 2: 8b x4, 3: same as 0
//   reg_num                 results per frame (0 is treated as 1)
//   reg_clr                 pulse that aborts the current frame and clears sat_cnt
//   busy                    frame in progress or output word pending
//   sat_cnt                 saturating count of clipped results
module mac_out_pack #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SAT_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             d_TVALID,
  output logic             d_TREADY,
  input  logic [31:0]      d_TDATA,
  output logic             o_TVALID,
  input  logic             o_TREADY,
  output logic [31:0]      o_TDATA,
  output logic [3:0]       o_TKEEP,
  output logic             o_TLAST,
  input  logic [1:0]       reg_mode,
  input  logic [CNT_W-1:0] reg_num,
  input  logic             reg_clr,
  output logic             busy,
  output logic [SAT_W-1:0] sat_cnt
);

  typedef enum logic {S_IDLE, S_FILL} state_t;
  typedef enum logic [1:0] {M_W32 = 2'd0, M_W16 = 2'd1, M_W8 = 2'd2} mode_t;

  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode;
  logic [CNT_W-1:0] r_n, w_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic [31:0]      r_pack, w_pack_nxt;
  logic [3:0]       r_keep, w_keep_nxt;
  logic [31:0]      r_tdata;
  logic [3:0]       r_tkeep;
  logic             r_tvalid, r_tlast;
  logic [SAT_W-1:0] r_sat;

  logic             w_acc, w_last, w_complete, w_lane_end, w_clip;
  logic             w_fit16, w_fit8;
  logic [15:0]      w_v16;
  logic [7:0]       w_v8;
  logic [31:0]      w_lane_data;
  logic [3:0]       w_lane_keep;

  assign d_TREADY = ~ap_rst & (~r_tvalid | o_TREADY);
  // An input arriving together with reg_clr is dropped.
  assign w_acc    = d_TVALID & d_TREADY & ~reg_clr;

  assign o_TVALID = r_tvalid;
  assign o_TDATA  = r_tdata;
  assign o_TKEEP  = r_tkeep;
  assign o_TLAST  = r_tlast;
  assign sat_cnt  = r_sat;
  assign busy     = (r_cnt != '0) | r_tvalid;

  // At frame start, use the live configuration. After that, use the latched copy.
  always_comb begin
    w_mode = r_mode;
    w_n    = r_n;
    if (r_state == S_IDLE) begin
      case (reg_mode)
        2'd1:    w_mode = M_W16;
        2'd2:    w_mode = M_W8;
        default: w_mode = M_W32;
      endcase
      w_n = (reg_num == '0) ? CNT_W'(1) : reg_num;
    end
  end

  // A value fits in W bits when all bits above W-2 equal the sign bit.
  assign w_fit16 = (&d_TDATA[31:15]) | ~(|d_TDATA[31:15]);
  assign w_fit8  = (&d_TDATA[31:7])  | ~(|d_TDATA[31:7]);
  assign w_v16   = w_fit16 ? d_TDATA[15:0] : (d_TDATA[31] ? 16'h8000 : 16'h7FFF);
  assign w_v8    = w_fit8  ? d_TDATA[7:0]  : (d_TDATA[31] ? 8'h80    : 8'h7F);

  always_comb begin
    w_lane_data = d_TDATA;
    w_lane_keep = 4'hF;
    w_lane_end  = 1'b1;
    w_clip      = 1'b0;
    case (w_mode)
      M_W16: begin
        w_lane_data = r_lane[0] ? {w_v16, 16'h0000} : {16'h0000, w_v16};
        w_lane_keep = r_lane[0] ? 4'b1100 : 4'b0011;
        w_lane_end  = r_lane[0];
        w_clip      = ~w_fit16;
      end
      M_W8: begin
        w_lane_data = {24'h000000, w_v8} << {r_lane, 3'b000};
        w_lane_keep = 4'b0001 << r_lane;
        w_lane_end  = (r_lane == 2'd3);
        w_clip      = ~w_fit8;
      end
      default: ;
    endcase
  end

  assign w_last     = (r_cnt == (w_n - CNT_W'(1)));
  assign w_complete = w_lane_end | w_last;
  assign w_pack_nxt = r_pack | w_lane_data;
  assign w_keep_nxt = r_keep | w_lane_keep;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lane_nxt  = r_lane;
    if (reg_clr) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_lane_nxt  = '0;
    end else if (w_acc) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_lane_nxt  = '0;
      end else begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_lane_nxt  = w_complete ? 2'd0 : r_lane + 2'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state  <= S_IDLE;
      r_mode   <= M_W32;
      r_n      <= '0;
      r_cnt    <= '0;
      r_lane   <= '0;
      r_pack   <= '0;
      r_keep   <= '0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
      r_sat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lane  <= w_lane_nxt;

      if (w_acc && (r_state == S_IDLE)) begin
        r_mode <= w_mode;
        r_n    <= w_n;
      end

      if (reg_clr || (w_acc && w_complete)) begin
        r_pack <= '0;
        r_keep <= '0;
      end else if (w_acc) begin
        r_pack <= w_pack_nxt;
        r_keep <= w_keep_nxt;
      end

      // w_acc implies the output register is free or being drained this cycle.
      if (w_acc && w_complete) begin
        r_tdata  <= w_pack_nxt;
        r_tkeep  <= w_keep_nxt;
        r_tlast  <= w_last;
        r_tvalid <= 1'b1;
      end else if (r_tvalid && o_TREADY) begin
        r_tvalid <= 1'b0;
      end

      if (reg_clr) begin
        r_sat <= '0;
      end else if (w_acc && w_clip && !(&r_sat)) begin
        r_sat <= r_sat + SAT_W'(1);
      end
    end
  end

endmodule

// File: doc/mac_out_pack.md
Name: mac_out_pack

Overview:
- Downstream neighbour of the MAC engine. Consumes its 32-bit signed result stream d.
- Optionally saturates each result to 16 or 8 bits, packs 1/2/4 results into a 32-bit output word, and frames every reg_num results with TLAST/TKEEP.
- Output is an AXI-Stream-like source towards the writeback DMA.
- Also exposes a saturation event counter and a busy flag to the control registers.

Parameters:
- CNT_W, 16, width of frame-length register and internal element counter
- SAT_W, 16, width of saturation event counter

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  reset, synchronous, active-high
- d_TVALID  in  1  input result valid
- d_TREADY  out  1  input result ready
- d_TDATA  in  32  input result, signed two's complement
- o_TVALID  out  1  packed word valid
- o_TREADY  in  1  packed word ready
- o_TDATA  out  32  packed word, lane 0 at LSBs
- o_TKEEP  out  4  byte-valid mask of o_TDATA
- o_TLAST  out  1  last word of frame
- reg_mode  in  2  0: 32b passthrough, 1: 16b x2, 2: 8b x4, 3: treated as 0
- reg_num  in  CNT_W  results per frame; 0 treated as 1
- reg_clr  in  1  single-cycle pulse: abort current frame, clear sat_cnt
- busy  out  1  frame in progress or output word pending
- sat_cnt  out  SAT_W  count of clipped results

Behaviour:

Reset:
- While ap_rst=1: o_TVALID=0, o_TDATA=0, o_TKEEP=0, o_TLAST=0, d_TREADY=0, busy=0, sat_cnt=0, element counter=0, packing register=0.
- Reset mid-frame discards all state, including a pending output word.

Handshake:
- d_TREADY = ~ap_rst & (~o_TVALID | o_TREADY).
- An input is accepted on d_TVALID & d_TREADY.
- Once o_TVALID=1, o_TDATA/o_TKEEP/o_TLAST are held stable until o_TVALID & o_TREADY.
- o_TVALID never depends combinationally on o_TREADY.

Configuration:
- Lane count L = 1/2/4 and element width W = 32/16/8 are latched from reg_mode.
- frame length N = max(reg_num, 1) is latched with them.
- Latching happens on the first accepted result of a frame (counter==0). Changes mid-frame are ignored.

Saturation:
- Mode 0: no clipping.
- Modes 1/2: clip to [-2^(W-1), 2^(W-1)-1]; for W=8 that is [-128, 127].
- Lane value is the low W bits of the clipped result.
- sat_cnt increments by 1 per clipped result and sticks at 2^SAT_W-1.

Packing state machine:
- States: IDLE (counter==0, lane index 0), FILL (partial word held).
- Result k of the frame goes to lane k mod L, bits [W*(k mod L) +: W].
- A word completes when lane L-1 is written or k==N-1.
- On a completing accept, the output register loads, next cycle (latency 1 cycle):
  - o_TDATA = packed lanes, unused lanes = 0
  - o_TKEEP = one bit per filled byte
  - o_TLAST = (k==N-1)
- The packing register then clears.
- On k==N-1: counter returns to 0, state goes to IDLE, and the next result re-latches configuration.
- A non-completing accept only writes its lane; o_TVALID is unchanged.

Simultaneous events:
- Output handshake and a completing input in the same cycle: the new word loads and o_TVALID stays 1.
- Output handshake with a non-completing or no input: o_TVALID goes to 0.
- Throughput is 1 word/cycle in mode 0.

reg_clr:
- Clears counter, lane index, packing register and sat_cnt, and returns to IDLE.
- A word already presented on o_* is kept until its handshake.
- An input accepted in the same cycle as reg_clr is dropped.

busy:
- busy = (counter != 0) | o_TVALID.

Test Plan:
1. Mode 0, N=3, inputs 5, -7, 0x7FFFFFFF, o_TREADY=1 -> three words, TKEEP=4'hF, TLAST only on third, one word per cycle, latency 1 cycle.
2. Mode 2, N=4, inputs 1, -1, 200, -300 -> one word 0x80_7F_FF_01, TKEEP=4'hF, TLAST=1, sat_cnt=2.
3. Mode 1, N=3, inputs 0x1234, 0x40000, 7 -> word0=0x7FFF_1234 (TLAST=0), word1=0x0000_0007 with TKEEP=4'b0011, TLAST=1, sat_cnt=1.
4. Backpressure: mode 0, o_TREADY=0 for 5 cycles with d_TVALID=1 -> d_TREADY=0 and o_TDATA stable throughout; on release, all data is delivered in order with none lost or duplicated.
5. reg_clr after 2 of 4 inputs in mode 2, then 4 new inputs 9, 9, 9, 9 -> single word 0x09090909 with TLAST=1; sat_cnt=0; busy=0 after the handshake.
6. ap_rst asserted while o_TVALID=1 mid-frame -> next cycle all outputs are 0 and d_TREADY=0; after release, a fresh frame (reg_num=0, mode 0, input 42) yields one word 42 with TLAST=1.
